uart_rx_param: RTL and testbench

- Parametrised UART receiver. Successor to the fixed 8N1 receiver that feeds the edge-detection image path.
- Configurable data width, parity mode, stop-bit count and baud divisor.
- Adds false-start rejection, parity and framing error flags, a valid/ready output handshake and overrun detection.
- Sits between the board rx pin and the pixel write logic; one instance per serial channel.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_sync.sv | 36 +++
 rtl/uart_rx_param.sv | 182 ++++++++++++++++++
 tb/tb_uart_rx_param.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants, state encoding and helpers
// for the parametrised UART receiver.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  // Rounded clock cycles per bit.
  function automatic int calc_baud_cnt(
    input int clk_hz,
    input int baud
  );
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial input
// plus an edge register for start detection.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s2,
  output logic start_fall
);

  logic rx_s1_q, rx_s1_d;
  logic rx_s2_q, rx_s2_d;
  logic rx_d_q,  rx_d_d;

  always_comb begin
    rx_s1_d = rx;
    rx_s2_d = rx_s1_q;
    rx_d_d  = rx_s2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_d_q  <= 1'b1;
    end else begin
      rx_s1_q <= rx_s1_d;
      rx_s2_q <= rx_s2_d;
      rx_d_q  <= rx_d_d;
    end
  end

  assign rx_s2      = rx_s2_q;
  assign start_fall = !rx_s2_q && rx_d_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: FSM, baud counter,
// shift register and valid/ready output stage.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int BAUD_CNT_MAX = 52,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 board_clk,
  input  logic                 sys_rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] po_data,
  output logic                 po_valid,
  input  logic                 po_ready,
  output logic                 po_parity_err,
  output logic                 po_frame_err,
  output logic                 po_overrun
);

  localparam int CW = $clog2(BAUD_CNT_MAX);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(BAUD_CNT_MAX - 1);
  localparam logic [CW-1:0] CNT_MID =
    CW'(BAUD_CNT_MAX / 2 - 1);
  localparam logic [3:0] BIT_LAST =
    4'(DATA_BITS - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  logic rx_s2;
  logic start_fall;
  logic sample;
  logic done;
  logic load;

  rx_state_e state_q, state_d;

  logic [CW-1:0]        baud_cnt_q, baud_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_err_q, par_err_d;
  logic                 frm_err_q, frm_err_d;

  logic [DATA_BITS-1:0] po_data_q, po_data_d;
  logic                 po_valid_q, po_valid_d;
  logic                 po_perr_q, po_perr_d;
  logic                 po_ferr_q, po_ferr_d;
  logic                 po_ovr_q, po_ovr_d;

  uart_rx_sync u_sync (
    .clk        (board_clk),
    .rst_n      (sys_rst_n),
    .rx         (rx),
    .rx_s2      (rx_s2),
    .start_fall (start_fall)
  );

  assign sample = (baud_cnt_q == CNT_MID);
  assign done   = (state_q == STOP) && sample &&
                  (stop_cnt_q == STOP_LAST);
  assign load   = done && (!po_valid_q || po_ready);

  always_ff @(posedge board_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shreg_q    <= '0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      po_data_q  <= '0;
      po_valid_q <= 1'b0;
      po_perr_q  <= 1'b0;
      po_ferr_q  <= 1'b0;
      po_ovr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shreg_q    <= shreg_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      po_data_q  <= po_data_d;
      po_valid_q <= po_valid_d;
      po_perr_q  <= po_perr_d;
      po_ferr_q  <= po_ferr_d;
      po_ovr_q   <= po_ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_fall) state_d = START;
      end
      START: begin
        if (sample) state_d = rx_s2 ? IDLE : DATA;
      end
      DATA: begin
        if (sample && bit_cnt_q == BIT_LAST)
          state_d = (PARITY_MODE != PARITY_NONE) ?
                    PARITY : STOP;
      end
      PARITY: begin
        if (sample) state_d = STOP;
      end
      STOP: begin
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    baud_cnt_d = (baud_cnt_q == CNT_LAST) ?
                 '0 : baud_cnt_q + 1'b1;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shreg_d    = shreg_q;
    par_err_d  = par_err_q;
    frm_err_d  = frm_err_q;

    if (state_q == IDLE && start_fall)
      baud_cnt_d = '0;

    if (sample) begin
      unique case (state_q)
        START: begin
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          par_err_d  = 1'b0;
          frm_err_d  = 1'b0;
        end
        DATA: begin
          shreg_d   = {rx_s2, shreg_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
        PARITY: begin
          par_err_d = (PARITY_MODE == PARITY_EVEN) ?
                      (^shreg_q ^ rx_s2) :
                      ~(^shreg_q ^ rx_s2);
        end
        STOP: begin
          if (!rx_s2) frm_err_d = 1'b1;
          stop_cnt_d = stop_cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    po_data_d  = po_data_q;
    po_perr_d  = po_perr_q;
    po_ferr_d  = po_ferr_q;
    po_valid_d = po_valid_q;
    po_ovr_d   = done && po_valid_q && !po_ready;

    if (load) begin
      po_data_d  = shreg_q;
      // Current stop sample is not yet in frm_err_q.
      po_ferr_d  = frm_err_q | ~rx_s2;
      po_perr_d  = (PARITY_MODE != PARITY_NONE) &&
                   par_err_q;
      po_valid_d = 1'b1;
    end else if (po_valid_q && po_ready) begin
      po_valid_d = 1'b0;
    end
  end

  assign po_data       = po_data_q;
  assign po_valid      = po_valid_q;
  assign po_parity_err = po_perr_q;
  assign po_frame_err  = po_ferr_q;
  assign po_overrun    = po_ovr_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations,
// frame-level model queue and per-cycle compare.
module tb_uart_rx_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] rx = 3'b111;
  logic [2:0] rdy = 3'b111;
  logic [2:0][7:0] pd;
  logic [2:0] pv, pe, fe, ov;

  always #5 clk = ~clk;

  uart_rx_param #(.BAUD_CNT_MAX(52)) u0 (
    .board_clk(clk), .sys_rst_n(rst_n), .rx(rx[0]),
    .po_data(pd[0]), .po_valid(pv[0]),
    .po_ready(rdy[0]), .po_parity_err(pe[0]),
    .po_frame_err(fe[0]), .po_overrun(ov[0]));

  uart_rx_param #(.BAUD_CNT_MAX(16),
                  .PARITY_MODE(2)) u1 (
    .board_clk(clk), .sys_rst_n(rst_n), .rx(rx[1]),
    .po_data(pd[1]), .po_valid(pv[1]),
    .po_ready(rdy[1]), .po_parity_err(pe[1]),
    .po_frame_err(fe[1]), .po_overrun(ov[1]));

  uart_rx_param #(.BAUD_CNT_MAX(16),
                  .STOP_BITS(2)) u2 (
    .board_clk(clk), .sys_rst_n(rst_n), .rx(rx[2]),
    .po_data(pd[2]), .po_valid(pv[2]),
    .po_ready(rdy[2]), .po_parity_err(pe[2]),
    .po_frame_err(fe[2]), .po_overrun(ov[2]));

  typedef struct {
    int inst;
    logic [7:0] d;
    logic pe;
    logic fe;
  } exp_t;

  exp_t expq[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ovcnt[3] = '{0, 0, 0};
  int pres_cyc[3] = '{0, 0, 0};
  logic [2:0] pv_prev = '0;
  logic [2:0] pr_prev = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string name,
                       input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, req);
    end
  endtask

  // A word is presented when valid rises or stays
  // high right after an accept.
  always @(negedge clk) begin
    if (!rst_n) begin
      pv_prev = '0;
      pr_prev = '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (pv[i] && (!pv_prev[i] || pr_prev[i])) begin
          int idx;
          idx = -1;
          pres_cyc[i] = cyc;
          for (int k = 0; k < expq.size(); k++)
            if (idx < 0 && expq[k].inst == i) idx = k;
          if (idx < 0) begin
            check($sformatf("unexpected_word_u%0d", i),
                  int'(pd[i]), -1);
          end else begin
            check($sformatf("data_u%0d", i),
                  int'(pd[i]), int'(expq[idx].d));
            check($sformatf("perr_u%0d", i),
                  int'(pe[i]), int'(expq[idx].pe));
            check($sformatf("ferr_u%0d", i),
                  int'(fe[i]), int'(expq[idx].fe));
            expq.delete(idx);
          end
        end
        if (ov[i]) ovcnt[i]++;
      end
      pv_prev = pv;
      pr_prev = rdy;
    end
  end

  // Builds the wire bits of one frame from its fields.
  task automatic send(input int i, input logic [7:0] d,
                      input int par_force,
                      input logic s1, input logic s2,
                      input bit push, input int upto,
                      output int t0);
    int pm, ns, baud;
    logic good_par, pbit;
    logic b[$];
    pm = (i == 1) ? 2 : 0;
    ns = (i == 2) ? 2 : 1;
    baud = (i == 0) ? 52 : 16;
    good_par = ^d;
    pbit = (par_force < 0) ? good_par : par_force[0];
    b.push_back(1'b0);
    for (int k = 0; k < 8; k++) b.push_back(d[k]);
    if (pm != 0) b.push_back(pbit);
    b.push_back(s1);
    if (ns == 2) b.push_back(s2);
    if (push)
      expq.push_back('{i, d,
        (pm != 0) && (pbit != good_par),
        !s1 || (ns == 2 && !s2)});
    t0 = 0;
    for (int k = 0; k < b.size() && k < upto; k++) begin
      #1 rx[i] = b[k];
      if (k == 0) t0 = cyc;
      repeat (baud) @(posedge clk);
    end
  endtask

  task automatic drain(input int budget);
    for (int n = 0; n < budget; n++) begin
      if (expq.size() == 0) break;
      @(posedge clk);
    end
    check("drain_timeout", expq.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_valid_u%0d", tag, i),
            int'(pv[i]), 0);
      check($sformatf("%s_data_u%0d", tag, i),
            int'(pd[i]), 0);
      check($sformatf("%s_flags_u%0d", tag, i),
            int'({pe[i], fe[i], ov[i]}), 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, lat;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // 8N1 single word and its latency
    send(0, 8'hA5, -1, 1, 1, 1, 99, t0);
    drain(600);
    lat = pres_cyc[0] - t0;
    checks++;
    if (lat < 497 || lat > 499) begin
      failures++;
      $display("FAIL latency actual=%0d required=497..499",
               lat);
    end
    check("a5_literal", int'(pd[0]), 8'hA5);

    // back to back
    send(0, 8'h00, -1, 1, 1, 1, 99, t0);
    send(0, 8'hFF, -1, 1, 1, 1, 99, t0);
    send(0, 8'h3C, -1, 1, 1, 1, 99, t0);
    drain(600);
    check("b2b_overrun", ovcnt[0], 0);
    check("b2b_last_literal", int'(pd[0]), 8'h3C);

    // 10-cycle glitch then a real frame
    #1 rx[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1 rx[0] = 1'b1;
    repeat (80) @(posedge clk);
    check("glitch_no_valid", int'(pv[0]), 0);
    send(0, 8'h5A, -1, 1, 1, 1, 99, t0);
    drain(600);

    // break: line stays low after the frame
    send(0, 8'h00, -1, 0, 1, 1, 99, t0);
    drain(600);
    check("break_ferr_literal", int'(fe[0]), 1);
    repeat (600) @(posedge clk);
    #1 rx[0] = 1'b1;
    repeat (60) @(posedge clk);
    send(0, 8'hC6, -1, 1, 1, 1, 99, t0);
    drain(600);

    // even parity
    send(1, 8'h07, 0, 1, 1, 1, 99, t0);
    drain(200);
    check("par_bad_literal", int'(pe[1]), 1);
    send(1, 8'h07, 1, 1, 1, 1, 99, t0);
    drain(200);
    check("par_good_literal", int'(pe[1]), 0);

    // two stop bits, second low
    send(2, 8'h81, -1, 1, 0, 1, 99, t0);
    drain(200);
    check("stop2_ferr_literal", int'(fe[2]), 1);
    #1 rx[2] = 1'b1;
    repeat (32) @(posedge clk);

    // overrun with consumer stalled
    #1 rdy[2] = 1'b0;
    send(2, 8'h11, -1, 1, 1, 1, 99, t0);
    send(2, 8'h22, -1, 1, 1, 0, 99, t0);
    repeat (20) @(posedge clk);
    check("overrun_pulses", ovcnt[2], 1);
    check("held_valid", int'(pv[2]), 1);
    check("held_data", int'(pd[2]), 8'h11);

    // reset during data bit 4 of 0xC3
    send(2, 8'hC3, -1, 1, 1, 0, 5, t0);
    #1 rx[2] = 1'b0;
    repeat (8) @(posedge clk);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("midreset");
    #1 rx[2] = 1'b1;
    rdy[2] = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    check("post_reset_no_valid", int'(pv[2]), 0);
    send(2, 8'h99, -1, 1, 1, 1, 99, t0);
    drain(200);
    check("post_reset_literal", int'(pd[2]), 8'h99);

    repeat (20) @(posedge clk);
    check("queue_empty", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
